servant_wb_mux_n: RTL and testbench
===================================

Name: servant_wb_mux_n

Overview:
- Parametrised successor to the fixed-map servant data-bus mux.
- Routes SERV dbus Wishbone accesses to NUM_SLAVES peripherals, decoded from an address field.
- Supports mixed native-ack and fixed-latency (ack-less) slaves per a mask.
- Adds a bus-timeout watchdog, unmapped-address error response and a sticky error/address capture for firmware diagnostics.

Parameters:
- NUM_SLAVES, 8, number of slave ports (2..16); SEL_W = $clog2(NUM_SLAVES) derived locally.
- SEL_LSB, 28, LSB of the address slave-select field adr[SEL_LSB +: SEL_W].
- ACK_MASK, {NUM_SLAVES{1'b1}}, bit i=1: slave i drives native ack; bit i=0: mux generates a fixed one-cycle ack.
- TIMEOUT, 255, max BUSY cycles waiting for native ack before error response (>=2).
- ERR_RDT, 32'hDEAD_BEEF, read data returned on any error response.

Ports:
- i_wb_clk  in  1  bus clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_wb_cpu_adr  in  32  CPU address
- i_wb_cpu_dat  in  32  CPU write data
- i_wb_cpu_sel  in  4  byte enables
- i_wb_cpu_we  in  1  write enable
- i_wb_cpu_cyc  in  1  cycle request
- o_wb_cpu_rdt  out  32  read data (registered)
- o_wb_cpu_ack  out  1  one-cycle acknowledge
- o_wb_s_adr  out  32  shared slave address (pass-through)
- o_wb_s_dat  out  32  shared slave write data
- o_wb_s_sel  out  4  shared byte enables
- o_wb_s_we  out  1  shared write enable
- o_wb_s_cyc  out  NUM_SLAVES  one-hot slave cycle strobes
- i_wb_s_rdt  in  NUM_SLAVES*32  packed slave read data, slave i at [32*i +: 32]
- i_wb_s_ack  in  NUM_SLAVES  per-slave ack (ignored where ACK_MASK bit is 0)
- i_err_clr  in  1  clear sticky error
- o_err  out  1  sticky bus-error flag
- o_err_adr  out  32  address of first error since last clear

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; o_wb_cpu_ack=0, o_wb_cpu_rdt=0, o_wb_s_cyc=0, o_err=0, o_err_adr=0, timeout count=0.
  - Reset mid-transaction aborts it with no ack.
- Address, data, sel and we are passed combinationally to the shared slave outputs.
- o_wb_s_cyc[idx] = (state==BUSY) & (idx==latched index); all other bits 0.
- FSM states: IDLE, BUSY, RESP.
- IDLE: on i_wb_cpu_cyc=1, latch idx=adr[SEL_LSB +: SEL_W].
  - idx<NUM_SLAVES: go to BUSY, clear count.
  - idx>=NUM_SLAVES (unmapped): go to RESP with rdt=ERR_RDT and flag the error.
- BUSY, fixed slave (ACK_MASK[idx]=0): exactly one cycle; capture i_wb_s_rdt slice; go to RESP.
- BUSY, native slave: count increments each cycle.
  - On i_wb_s_ack[idx]=1: capture rdt slice, go to RESP.
  - Else if count==TIMEOUT-1: rdt=ERR_RDT, flag error, go to RESP.
  - Ack and timeout in the same cycle: ack wins, no error.
- RESP: o_wb_cpu_ack=1 for exactly one cycle, rdt held; go to IDLE.
  - SERV drops cyc the cycle after ack, so no re-trigger occurs.
- Latency from cyc sampled in IDLE to ack:
  - fixed slave: 2 cycles;
  - native slave: (ack cycle in BUSY)+1;
  - unmapped: 1 cycle;
  - timeout: TIMEOUT+1 cycles.
- Writes to unmapped or timed-out slaves are acked with no side effect; rdt=ERR_RDT regardless of we.
- Error capture:
  - o_err set on unmapped or timeout.
  - o_err_adr loads the CPU address only when o_err is 0 (first error kept).
  - i_err_clr clears o_err; a simultaneous set and clear resolves to set, with the address loaded.
- Outputs other than the shared pass-through buses are registered.

Decomposition:
- Shared package/header servant_wb_pkg:
  - FSM state encodings (IDLE=2'd0, BUSY=2'd1, RESP=2'd2);
  - default ERR_RDT constant;
  - SEL_W helper.
- One sub-module, servant_wb_timeout: counter with clear/enable/expire, width $clog2(TIMEOUT+1).

Test Plan:
- Fixed slave 2 (ACK_MASK=8'b1111_1011): read adr=32'h2000_0004, slave2 rdt=32'h1234_5678 -> o_wb_s_cyc=8'b0000_0100 for one cycle, ack 2 cycles after cyc, rdt=32'h1234_5678, o_err=0.
- Native slave 5 acks after 3 BUSY cycles: write adr=32'h5000_0000, dat=32'hA5A5_A5A5 -> o_wb_s_cyc[5] high 3 cycles, shared dat=32'hA5A5_A5A5, we=1, single ack pulse.
- Timeout with TIMEOUT=16, slave 1 never acks, adr=32'h1000_0010 -> ack 17 cycles after cyc, rdt=32'hDEAD_BEEF, o_err=1, o_err_adr=32'h1000_0010; a second timeout at 32'h1000_0020 leaves o_err_adr unchanged.
- NUM_SLAVES=6, adr=32'h7000_0000 -> no o_wb_s_cyc bit set, ack 1 cycle after cyc, rdt=32'hDEAD_BEEF, o_err=1; i_err_clr pulse -> o_err=0.
- Slave ack on the count==TIMEOUT-1 cycle -> normal rdt returned, o_err stays 0; an error event concurrent with i_err_clr -> o_err=1.
- i_rst_n low mid-BUSY -> o_wb_s_cyc=0, ack=0 immediately; after release a fresh read completes normally.

Source files
------------

// File: rtl/servant_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : servant_wb_pkg
// Purpose : Shared definitions for the parametrised servant data-bus mux:
//           FSM state encoding, default error read-data word and the
//           slave-select field width helper.
// Revision: 1.0 - initial release
// ============================================================================
package servant_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_ERR_RDT = 32'hDEAD_BEEF;

  // Width of the slave-select field; never less than one bit.
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/servant_wb_timeout.sv
`default_nettype none
// ============================================================================
// Module  : servant_wb_timeout
// Purpose : Bus watchdog counter. Cleared at the start of a slave access,
//           incremented while enabled, flags the last permitted cycle.
// Ports   : clk    - bus clock
//           rst_n  - asynchronous active-low reset
//           clr    - synchronous clear (priority over en)
//           en     - count enable
//           expire - high while count == TIMEOUT-1
// Revision: 1.0 - initial release
// ============================================================================
module servant_wb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // Left ungated by en so the consumer's enable logic never loops back here.
  assign expire = (count == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/servant_wb_mux_n.sv
`default_nettype none
// ============================================================================
// Module  : servant_wb_mux_n
// Purpose : Routes SERV dbus Wishbone accesses to NUM_SLAVES peripherals
//           selected by adr[SEL_LSB +: SEL_W]. Slaves either return a native
//           ack or are given a fixed one-cycle access (ACK_MASK bit = 0).
//           Unmapped accesses and native slaves that exceed TIMEOUT busy
//           cycles receive an error response (ERR_RDT) and set a sticky
//           error flag with first-error address capture.
// Ports   : i_wb_clk, i_rst_n          - clock, async active-low reset
//           i_wb_cpu_*                 - CPU-side Wishbone request
//           o_wb_cpu_rdt/ack           - registered CPU response
//           o_wb_s_adr/dat/sel/we      - shared slave request (pass-through)
//           o_wb_s_cyc                 - one-hot registered slave strobes
//           i_wb_s_rdt/ack             - packed slave responses
//           i_err_clr, o_err, o_err_adr - sticky error diagnostics
// Revision: 1.0 - initial release
// ============================================================================
module servant_wb_mux_n
  import servant_wb_pkg::*;
#(
  parameter int                    NUM_SLAVES = 8,
  parameter int                    SEL_LSB    = 28,
  parameter logic [NUM_SLAVES-1:0] ACK_MASK   = {NUM_SLAVES{1'b1}},
  parameter int                    TIMEOUT    = 255,
  parameter logic [31:0]           ERR_RDT    = DEFAULT_ERR_RDT
) (
  input  logic                     i_wb_clk,
  input  logic                     i_rst_n,
  input  logic [31:0]              i_wb_cpu_adr,
  input  logic [31:0]              i_wb_cpu_dat,
  input  logic [3:0]               i_wb_cpu_sel,
  input  logic                     i_wb_cpu_we,
  input  logic                     i_wb_cpu_cyc,
  output logic [31:0]              o_wb_cpu_rdt,
  output logic                     o_wb_cpu_ack,
  output logic [31:0]              o_wb_s_adr,
  output logic [31:0]              o_wb_s_dat,
  output logic [3:0]               o_wb_s_sel,
  output logic                     o_wb_s_we,
  output logic [NUM_SLAVES-1:0]    o_wb_s_cyc,
  input  logic [NUM_SLAVES*32-1:0] i_wb_s_rdt,
  input  logic [NUM_SLAVES-1:0]    i_wb_s_ack,
  input  logic                     i_err_clr,
  output logic                     o_err,
  output logic [31:0]              o_err_adr
);

  localparam int SEL_W = sel_w(NUM_SLAVES);
  localparam int MAP_N = 1 << SEL_W;

  state_t                  state, state_nxt;
  logic [SEL_W-1:0]        idx, idx_nxt;
  logic [SEL_W-1:0]        adr_idx;
  logic [MAP_N-1:0]        mapped;
  logic [31:0]             sel_rdt;
  logic                    sel_ack;
  logic                    sel_native;
  logic [31:0]             rdt_nxt;
  logic [NUM_SLAVES-1:0]   cyc_nxt;
  logic                    err_evt;
  logic                    tmo_clr;
  logic                    tmo_en;
  logic                    tmo_expire;

  // Shared request buses are pure pass-through.
  assign o_wb_s_adr = i_wb_cpu_adr;
  assign o_wb_s_dat = i_wb_cpu_dat;
  assign o_wb_s_sel = i_wb_cpu_sel;
  assign o_wb_s_we  = i_wb_cpu_we;

  assign adr_idx = i_wb_cpu_adr[SEL_LSB +: SEL_W];

  // Select codes beyond NUM_SLAVES are unmapped (only possible for
  // non-power-of-two slave counts).
  always_comb begin
    mapped = '0;
    for (int i = 0; i < MAP_N; i++) begin
      mapped[i] = (i < NUM_SLAVES);
    end
  end

  // Response mux driven by the latched index.
  always_comb begin
    sel_rdt    = '0;
    sel_ack    = 1'b0;
    sel_native = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx == SEL_W'(i)) begin
        sel_rdt    = i_wb_s_rdt[32*i +: 32];
        sel_ack    = i_wb_s_ack[i];
        sel_native = ACK_MASK[i];
      end
    end
  end

  servant_wb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk    (i_wb_clk),
    .rst_n  (i_rst_n),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rdt_nxt   = o_wb_cpu_rdt;
    err_evt   = 1'b0;
    tmo_clr   = 1'b0;
    tmo_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_wb_cpu_cyc) begin
          idx_nxt = adr_idx;
          if (mapped[adr_idx]) begin
            state_nxt = ST_BUSY;
            tmo_clr   = 1'b1;
          end else begin
            state_nxt = ST_RESP;
            rdt_nxt   = ERR_RDT;
            err_evt   = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (!sel_native) begin
          state_nxt = ST_RESP;
          rdt_nxt   = sel_rdt;
        end else begin
          tmo_en = 1'b1;
          // A native ack on the expiry cycle takes precedence.
          if (sel_ack) begin
            state_nxt = ST_RESP;
            rdt_nxt   = sel_rdt;
          end else if (tmo_expire) begin
            state_nxt = ST_RESP;
            rdt_nxt   = ERR_RDT;
            err_evt   = 1'b1;
          end
        end
      end
      ST_RESP: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Strobes are computed from next state so they are registered outputs.
  always_comb begin
    cyc_nxt = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      cyc_nxt[i] = (state_nxt == ST_BUSY) && (idx_nxt == SEL_W'(i));
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      idx          <= '0;
      o_wb_cpu_rdt <= '0;
      o_wb_cpu_ack <= 1'b0;
      o_wb_s_cyc   <= '0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      o_wb_cpu_rdt <= rdt_nxt;
      o_wb_cpu_ack <= (state_nxt == ST_RESP);
      o_wb_s_cyc   <= cyc_nxt;
    end
  end

  // Sticky error: set beats clear; the address of the first error after a
  // clear is kept, and a clear coinciding with a new error re-arms capture.
  always_ff @(posedge i_wb_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_err     <= 1'b0;
      o_err_adr <= '0;
    end else if (err_evt) begin
      o_err <= 1'b1;
      if (!o_err || i_err_clr) begin
        o_err_adr <= i_wb_cpu_adr;
      end
    end else if (i_err_clr) begin
      o_err <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_servant_wb_mux_n.sv
`default_nettype none
// ============================================================================
// Module  : tb_servant_wb_mux_n
// Purpose : Self-checking bench for servant_wb_mux_n with six slaves
//           (slave 2 fixed-latency, others native ack), TIMEOUT=16.
// Revision: 1.0 - initial release
// ============================================================================
module tb_servant_wb_mux_n;

  localparam int NS  = 6;
  localparam int TMO = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       adr, dat;
  logic [3:0]        sel;
  logic              we, cyc;
  logic [31:0]       rdt;
  logic              ack;
  logic [31:0]       s_adr, s_dat;
  logic [3:0]        s_sel;
  logic              s_we;
  logic [NS-1:0]     s_cyc;
  logic [NS*32-1:0]  s_rdt;
  logic [NS-1:0]     s_ack;
  logic              err_clr;
  logic              err;
  logic [31:0]       err_adr;

  int ack_delay;
  int busy_cnt;
  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  servant_wb_mux_n #(
    .NUM_SLAVES (NS),
    .SEL_LSB    (28),
    .ACK_MASK   (6'b111011),
    .TIMEOUT    (TMO),
    .ERR_RDT    (32'hDEAD_BEEF)
  ) dut (
    .i_wb_clk     (clk),
    .i_rst_n      (rst_n),
    .i_wb_cpu_adr (adr),
    .i_wb_cpu_dat (dat),
    .i_wb_cpu_sel (sel),
    .i_wb_cpu_we  (we),
    .i_wb_cpu_cyc (cyc),
    .o_wb_cpu_rdt (rdt),
    .o_wb_cpu_ack (ack),
    .o_wb_s_adr   (s_adr),
    .o_wb_s_dat   (s_dat),
    .o_wb_s_sel   (s_sel),
    .o_wb_s_we    (s_we),
    .o_wb_s_cyc   (s_cyc),
    .i_wb_s_rdt   (s_rdt),
    .i_wb_s_ack   (s_ack),
    .i_err_clr    (err_clr),
    .o_err        (err),
    .o_err_adr    (err_adr)
  );

  // Slave model: acks on the ack_delay-th cycle its strobe is high
  // (ack_delay==0 means never).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)          busy_cnt <= 0;
    else if (s_cyc == 0) busy_cnt <= 0;
    else                 busy_cnt <= busy_cnt + 1;
  end
  assign s_ack = (ack_delay != 0 && busy_cnt == ack_delay - 1) ? s_cyc : '0;

  typedef struct {
    logic          pre_clr;   // pulse err_clr before this access
    logic          clr_with;  // hold err_clr on the request-sampling edge
    logic [31:0]   adr;
    logic [31:0]   dat;
    logic          we;
    int            dly;
    logic [31:0]   rdt;
    int            lat;
    int            busy;
    logic [NS-1:0] onehot;
    logic          err;
    logic [31:0]   err_adr;
  } vec_t;

  vec_t sb[$];
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    vec_t e;
    int   lat;
    int   busy;
    bit   bad;
    bit   got;
    if (v.pre_clr) begin
      @(negedge clk); err_clr = 1'b1;
      @(posedge clk); #1; err_clr = 1'b0;
      chk("err_after_clr", {31'd0, err}, 32'd0);
    end
    @(negedge clk);
    adr = v.adr; dat = v.dat; we = v.we; sel = 4'hF; cyc = 1'b1;
    ack_delay = v.dly; err_clr = v.clr_with;
    sb.push_back(v);
    #1;
    chk("pass_adr", s_adr, v.adr);
    chk("pass_dat", s_dat, v.dat);
    chk("pass_we_sel", {27'd0, s_sel, s_we}, {27'd0, 4'hF, v.we});
    lat = 0; busy = 0; bad = 0; got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      err_clr = 1'b0;
      lat++;
      if (s_cyc != 0) begin
        busy++;
        if (s_cyc !== v.onehot) bad = 1;
      end
      if (ack) got = 1;
    end
    cyc = 1'b0;
    e = sb.pop_front();
    if (!got) begin
      chk("ack_seen", 32'd0, 32'd1);
    end else begin
      chk("rdt", rdt, e.rdt);
      chk("latency", 32'(lat), 32'(e.lat));
      chk("busy_cycles", 32'(busy), 32'(e.busy));
      chk("cyc_onehot_ok", {31'd0, bad}, 32'd0);
      chk("err", {31'd0, err}, {31'd0, e.err});
      chk("err_adr", err_adr, e.err_adr);
    end
    @(posedge clk); #1;
    chk("ack_single_pulse", {31'd0, ack}, 32'd0);
  endtask

  function automatic vec_t mk(input logic pc, input logic cw, input logic [31:0] a,
                              input logic [31:0] d, input logic w, input int dl,
                              input logic [31:0] r, input int l, input int b,
                              input logic [NS-1:0] oh, input logic e,
                              input logic [31:0] ea);
    vec_t v;
    v.pre_clr = pc; v.clr_with = cw; v.adr = a; v.dat = d; v.we = w; v.dly = dl;
    v.rdt = r; v.lat = l; v.busy = b; v.onehot = oh; v.err = e; v.err_adr = ea;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < NS; i++) begin
      s_rdt[32*i +: 32] = (i == 2) ? 32'h1234_5678 : (32'hC0DE_0000 + 32'(i));
    end
    rst_n = 1'b0; adr = '0; dat = '0; sel = '0; we = 1'b0; cyc = 1'b0;
    err_clr = 1'b0; ack_delay = 0;

    // Fixed slave, native slaves of varied latency, ack on the last
    // allowed cycle, timeouts, unmapped write, clear and clear-with-set.
    vecs[0] = mk(0, 0, 32'h2000_0004, 32'h0, 0, 0, 32'h1234_5678, 2, 1, 6'b000100, 0, 32'h0);
    vecs[1] = mk(0, 0, 32'h5000_0000, 32'hA5A5_A5A5, 1, 3, 32'hC0DE_0005, 4, 3, 6'b100000, 0, 32'h0);
    vecs[2] = mk(0, 0, 32'h0000_0008, 32'h0, 0, 1, 32'hC0DE_0000, 2, 1, 6'b000001, 0, 32'h0);
    vecs[3] = mk(0, 0, 32'h4000_0000, 32'h0, 0, TMO, 32'hC0DE_0004, TMO + 1, TMO, 6'b010000, 0, 32'h0);
    vecs[4] = mk(0, 0, 32'h1000_0010, 32'h0, 0, 0, 32'hDEAD_BEEF, TMO + 1, TMO, 6'b000010, 1, 32'h1000_0010);
    vecs[5] = mk(0, 0, 32'h1000_0020, 32'h0, 0, 0, 32'hDEAD_BEEF, TMO + 1, TMO, 6'b000010, 1, 32'h1000_0010);
    vecs[6] = mk(0, 0, 32'h7000_0000, 32'h1111_2222, 1, 0, 32'hDEAD_BEEF, 1, 0, 6'b000000, 1, 32'h1000_0010);
    vecs[7] = mk(1, 0, 32'h1000_0000, 32'h0, 0, TMO + 1, 32'hDEAD_BEEF, TMO + 1, TMO, 6'b000010, 1, 32'h1000_0000);
    vecs[8] = mk(1, 1, 32'h7000_0004, 32'h0, 0, 0, 32'hDEAD_BEEF, 1, 0, 6'b000000, 1, 32'h7000_0004);
    vecs[9] = mk(0, 0, 32'h6000_0000, 32'h0, 0, 0, 32'hDEAD_BEEF, 1, 0, 6'b000000, 1, 32'h7000_0004);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ack", {31'd0, ack}, 32'd0);
    chk("reset_rdt", rdt, 32'd0);
    chk("reset_cyc", {26'd0, s_cyc}, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    chk("reset_err_adr", err_adr, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Reset asserted while a native access is in BUSY.
    @(negedge clk);
    adr = 32'h3000_0000; we = 1'b0; cyc = 1'b1; ack_delay = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("busy_before_rst", {26'd0, s_cyc}, {26'd0, 6'b001000});
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", {26'd0, s_cyc}, 32'd0);
    chk("rst_mid_ack", {31'd0, ack}, 32'd0);
    chk("rst_mid_err", {31'd0, err}, 32'd0);
    cyc = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_txn(mk(0, 0, 32'h3000_0000, 32'h0, 0, 2, 32'hC0DE_0003, 3, 2, 6'b001000, 0, 32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
